// File: rtl/door_security_controller.sv
`timescale 1ns/1ps
// door_security_controller
//   Arm / exit-delay / armed / entry-delay / alarm sequencer for the door
//   contact, with a 4-digit keypad and a wrong-code lockout.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   magnetic_sensor   : 1 = door open
//   arm_req           : one-cycle arm request
//   key_valid/digit   : keypad strobe and BCD digit
//   locked, alarm     : lock actuator and siren drives (registered)
//   armed             : high in ARMED and ENTRY_DELAY (registered)
//   state             : current state encoding
//   bad_tries         : consecutive wrong-code count
module door_security_controller #(
    parameter int unsigned EXIT_CYCLES    = 20,
    parameter int unsigned ENTRY_CYCLES   = 15,
    parameter int unsigned SIREN_CYCLES   = 50,
    parameter int unsigned LOCKOUT_CYCLES = 40,
    parameter logic [15:0] PASSCODE       = 16'h1234,
    parameter int unsigned MAX_TRIES      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       magnetic_sensor,
    input  logic       arm_req,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       locked,
    output logic       alarm,
    output logic       armed,
    output logic [2:0] state,
    output logic [1:0] bad_tries
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    localparam logic [7:0] EXIT_LOAD    = 8'(EXIT_CYCLES - 1);
    localparam logic [7:0] ENTRY_LOAD   = 8'(ENTRY_CYCLES - 1);
    localparam logic [7:0] SIREN_LOAD   = 8'(SIREN_CYCLES - 1);
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0] MAX_TRIES_W  = 2'(MAX_TRIES);

    // Held as raw bits so the illegal encodings 6/7 stay representable
    // and are steered back to DISARMED by the default branch.
    logic [2:0]  state_q;
    state_t      state_n;
    logic [7:0]  timer_q;
    logic [7:0]  timer_load;
    logic [15:0] digits_q;
    logic [15:0] digits_shift;
    logic [1:0]  count_q;
    logic [1:0]  tries_inc;
    logic        key_take;
    logic        fourth;
    logic        code_ok;
    logic        code_bad;
    logic        lock_trig;
    logic        expired;

    assign state = state_q;

    always_comb begin
        key_take     = key_valid && (state_q != S_LOCKOUT);
        digits_shift = {digits_q[11:0], key_digit};
        fourth       = key_take && (count_q == 2'd3);
        code_ok      = fourth && (digits_shift == PASSCODE);
        code_bad     = fourth && !code_ok;
        tries_inc    = bad_tries + 2'd1;
        lock_trig    = code_bad && (tries_inc == MAX_TRIES_W);
        expired      = (timer_q == '0);
    end

    // Priority: lockout entry > code_ok > timer expiry > door/arm events.
    always_comb begin
        state_n = state_t'(state_q);
        if (lock_trig) begin
            state_n = S_LOCKOUT;
        end else begin
            case (state_q)
                S_DISARMED: if (arm_req && !magnetic_sensor) state_n = S_EXIT;
                S_EXIT: begin
                    if (code_ok)                          state_n = S_DISARMED;
                    else if (expired && !magnetic_sensor) state_n = S_ARMED;
                end
                S_ARMED: begin
                    if (code_ok)              state_n = S_DISARMED;
                    else if (magnetic_sensor) state_n = S_ENTRY;
                end
                S_ENTRY: begin
                    if (code_ok)      state_n = S_DISARMED;
                    else if (expired) state_n = S_ALARM;
                end
                S_ALARM: begin
                    if (code_ok)                          state_n = S_DISARMED;
                    else if (expired && !magnetic_sensor) state_n = S_ARMED;
                end
                S_LOCKOUT: if (expired) state_n = S_ALARM;
                default:   state_n = S_DISARMED;
            endcase
        end
    end

    always_comb begin
        case (state_n)
            S_EXIT:    timer_load = EXIT_LOAD;
            S_ENTRY:   timer_load = ENTRY_LOAD;
            S_ALARM:   timer_load = SIREN_LOAD;
            S_LOCKOUT: timer_load = LOCKOUT_LOAD;
            default:   timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DISARMED;
            timer_q   <= '0;
            digits_q  <= '0;
            count_q   <= '0;
            bad_tries <= '0;
            locked    <= 1'b0;
            alarm     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state_q <= state_n;

            // Reload on any state change and on expiry-while-staying,
            // which gives a full re-timed dwell when the door is open.
            if ((state_n != state_q) || expired)
                timer_q <= timer_load;
            else
                timer_q <= timer_q - 8'd1;

            if (lock_trig || (state_q == S_LOCKOUT)) begin
                digits_q <= '0;
                count_q  <= '0;
            end else if (key_take) begin
                digits_q <= digits_shift;
                count_q  <= count_q + 2'd1;  // wraps to 0 on the 4th digit
            end

            if ((state_q == S_LOCKOUT) && expired)
                bad_tries <= '0;
            else if (code_ok)
                bad_tries <= '0;
            else if (code_bad)
                bad_tries <= tries_inc;

            locked <= (state_n == S_ARMED) || (state_n == S_ENTRY) ||
                      (state_n == S_ALARM) || (state_n == S_LOCKOUT);
            alarm  <= (state_n == S_ALARM) || (state_n == S_LOCKOUT);
            armed  <= (state_n == S_ARMED) || (state_n == S_ENTRY);
        end
    end

endmodule
